// File: rtl/wb_host.sv
// Single-outstanding 8-bit WISHBONE classic initiator bridging a valid/ready
// request stream to one bus cycle and returning the result on a response stream.
module wb_host #(
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned RDATA_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_adr_i,
  input  logic [7:0]        req_dat_i,

  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [7:0]        rsp_dat_o,
  output logic              rsp_err_o,

  output logic              cyc_o,
  output logic              stb_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] adr_o,
  output logic [7:0]        dat_o,
  input  logic [7:0]        dat_i,
  input  logic              ack_i
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBus, StRdly, StResp} state_e;

  state_e              state_q;
  logic                cyc_q;
  logic                we_q;
  logic [ADDR_W-1:0]   adr_q;
  logic [7:0]          dat_q;
  logic [7:0]          rsp_dat_q;
  logic                rsp_err_q;
  logic [CntW-1:0]     cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            adr_q   <= req_adr_i;
            dat_q   <= req_dat_i;
            cnt_q   <= '0;
            cyc_q   <= 1'b1;
            state_q <= StBus;
          end
        end
        StBus: begin
          // Ack is checked before the timeout so an ack on the last cycle wins.
          if (ack_i) begin
            cyc_q <= 1'b0;
            if (we_q) begin
              rsp_dat_q <= '0;
              rsp_err_q <= 1'b0;
              state_q   <= StResp;
            end else if (RDATA_LAT == 0) begin
              rsp_dat_q <= dat_i;
              rsp_err_q <= 1'b0;
              state_q   <= StResp;
            end else begin
              state_q <= StRdly;
            end
          end else if (cnt_q == CntLast) begin
            cyc_q     <= 1'b0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b1;
            state_q   <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRdly: begin
          // Registered slaves present data one cycle after the address phase.
          rsp_dat_q <= dat_i;
          rsp_err_q <= 1'b0;
          state_q   <= StResp;
        end
        StResp: begin
          if (rsp_ready_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign cyc_o       = cyc_q;
  assign stb_o       = cyc_q;
  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;

endmodule

// File: tb/tb_wb_host.sv
// Randomised bench for wb_host against a transaction-level reference model
// with a register-file slave whose read data is registered one cycle late.
module tb_wb_host;

  localparam int TO = 15;

  logic       clk_i = 1'b0;
  logic       rst_n;
  always #5 clk_i = ~clk_i;

  // Main DUT (RDATA_LAT = 1)
  logic       req_valid, req_ready, req_we;
  logic [1:0] req_adr;
  logic [7:0] req_dat;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_dat;
  logic       cyc, stb, we, ack;
  logic [1:0] adr;
  logic [7:0] wdat, rdat;

  wb_host #(.ADDR_W(2), .TIMEOUT(TO), .RDATA_LAT(1)) u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_adr_i   (req_adr),
    .req_dat_i   (req_dat),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .cyc_o       (cyc),
    .stb_o       (stb),
    .we_o        (we),
    .adr_o       (adr),
    .dat_o       (wdat),
    .dat_i       (rdat),
    .ack_i       (ack)
  );

  // Second DUT (RDATA_LAT = 0) with a combinational zero-wait slave
  logic       r0_req_valid, r0_req_ready, r0_req_we;
  logic [1:0] r0_req_adr;
  logic [7:0] r0_req_dat;
  logic       r0_rsp_valid, r0_rsp_ready, r0_rsp_err;
  logic [7:0] r0_rsp_dat;
  logic       r0_cyc, r0_stb, r0_we;
  logic [1:0] r0_adr;
  logic [7:0] r0_wdat, r0_rdat;
  logic       r0_ack;
  assign r0_ack = r0_cyc & r0_stb;

  wb_host #(.ADDR_W(2), .TIMEOUT(TO), .RDATA_LAT(0)) u_dut0 (
    .clk_i       (clk_i),
    .rst_i       (rst_n),
    .req_valid_i (r0_req_valid),
    .req_ready_o (r0_req_ready),
    .req_we_i    (r0_req_we),
    .req_adr_i   (r0_req_adr),
    .req_dat_i   (r0_req_dat),
    .rsp_valid_o (r0_rsp_valid),
    .rsp_ready_i (r0_rsp_ready),
    .rsp_dat_o   (r0_rsp_dat),
    .rsp_err_o   (r0_rsp_err),
    .cyc_o       (r0_cyc),
    .stb_o       (r0_stb),
    .we_o        (r0_we),
    .adr_o       (r0_adr),
    .dat_o       (r0_wdat),
    .dat_i       (r0_rdat),
    .ack_i       (r0_ack)
  );

  // Slave environment: acks combinationally after wait_n wait states
  int         wait_n = 0;
  int         wcnt = 0;
  logic       ack_force = 1'b0;
  logic [7:0] smem [4];
  assign ack = ack_force | (cyc & stb & (wcnt == wait_n));

  always_ff @(posedge clk_i) begin
    wcnt <= cyc ? wcnt + 1 : 0;
    rdat <= smem[adr];
    if (cyc && stb && ack && we) smem[adr] <= wdat;
  end

  // Reference model state
  logic [7:0] ref_mem [4];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE after the handshake.
  task automatic txn(input bit t_we, input logic [1:0] t_adr, input logic [7:0] t_dat,
                     input int t_wait, input int t_bp);
    bit         acked;
    int         ec, exp_idx, cyc_n, idx;
    bit         got;
    logic [7:0] exp_dat;
    acked   = (t_wait + 1 <= TO);
    ec      = acked ? t_wait + 1 : TO;
    exp_dat = (!acked || t_we) ? 8'h00 : ref_mem[t_adr];
    exp_idx = ec + 1 + ((acked && !t_we) ? 1 : 0);
    if (acked && t_we) ref_mem[t_adr] = t_dat;

    wait_n    = t_wait;
    req_valid = 1'b1;
    req_we    = t_we;
    req_adr   = t_adr;
    req_dat   = t_dat;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    cyc_n = 0;
    got   = 1'b0;
    idx   = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_i);
      chk("stb_eq_cyc", {31'd0, stb}, {31'd0, cyc});
      if (cyc) begin
        cyc_n++;
        chk("bus_fields", {21'd0, we, adr, wdat}, {21'd0, t_we, t_adr, t_dat});
      end
      if (rsp_valid) begin
        got = 1'b1;
        idx = i;
        break;
      end
    end
    if (!got) begin
      chk("rsp_never_seen", 32'd0, 32'd1);
      return;
    end
    chk("rsp_latency", idx, exp_idx);
    chk("cyc_cycles", cyc_n, ec);
    chk("rsp_dat", {24'd0, rsp_dat}, {24'd0, exp_dat});
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, !acked});
    chk("adr_held", {30'd0, adr}, {30'd0, t_adr});
    // Backpressure with the request still asserted
    for (int i = 0; i < t_bp; i++) begin
      @(negedge clk_i);
      chk("bp_hold", {20'd0, rsp_valid, rsp_err, rsp_dat, req_ready, cyc},
          {20'd0, 1'b1, !acked, exp_dat, 1'b0, 1'b0});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk_i);
    rsp_ready = 1'b0;
    chk("back_to_idle", {30'd0, rsp_valid, req_ready}, {30'd0, 1'b0, 1'b1});
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      smem[i]    = 8'h00;
      ref_mem[i] = 8'h00;
    end
    rst_n = 1'b0;
    {req_valid, req_we, req_adr, req_dat, rsp_ready} = '0;
    {r0_req_valid, r0_req_we, r0_req_adr, r0_req_dat, r0_rsp_ready, r0_rdat} = '0;
    #1;
    chk("reset_outputs", {20'd0, cyc, stb, we, adr, wdat, rsp_valid},
        {20'd0, 14'd0});
    chk("reset_rsp", {23'd0, rsp_err, rsp_dat}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
    chk("ready_after_reset", {30'd0, req_ready, rsp_valid}, {30'd0, 1'b1, 1'b0});

    // Directed steps
    txn(1'b1, 2'd1, 8'hA5, 0, 0);     // zero-wait write
    txn(1'b1, 2'd2, 8'h3C, 0, 0);     // preload 0x3C
    txn(1'b0, 2'd2, 8'h00, 0, 0);     // registered read, RDATA_LAT = 1
    txn(1'b0, 2'd1, 8'h00, 1000, 0);  // timeout read
    txn(1'b1, 2'd3, 8'h77, 1000, 0);  // timeout write, no memory update
    txn(1'b1, 2'd3, 8'h99, 14, 0);    // ack on final timeout cycle
    txn(1'b0, 2'd3, 8'h00, 14, 0);
    txn(1'b1, 2'd0, 8'h81, 2, 0);     // wait-state slave
    txn(1'b0, 2'd0, 8'h00, 2, 0);

    // Ack held high afterwards must not start anything
    ack_force = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("stuck_ack_idle", {30'd0, cyc, rsp_valid}, 32'd0);
    end
    ack_force = 1'b0;

    txn(1'b0, 2'd1, 8'h00, 0, 10);    // backpressure
    txn(1'b1, 2'd2, 8'h5E, 0, 0);     // back-to-back

    // Asynchronous reset mid-wait
    wait_n    = 1000;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_adr   = 2'd3;
    req_dat   = 8'hC3;
    @(negedge clk_i);
    req_valid = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("cyc_before_reset", {31'd0, cyc}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_drop", {20'd0, cyc, stb, we, adr, wdat, rsp_valid}, 32'd0);
    chk("async_reset_rsp", {23'd0, rsp_err, rsp_dat}, 32'd0);
    @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
    chk("no_rsp_after_reset", {30'd0, rsp_valid, req_ready}, {30'd0, 1'b0, 1'b1});
    txn(1'b1, 2'd3, 8'h42, 0, 0);

    // Randomised transactions
    for (int n = 0; n < 40; n++) begin
      int w;
      case ($urandom_range(0, 6))
        0: w = 0;
        1: w = 1;
        2: w = 2;
        3: w = 3;
        4: w = 14;
        5: w = 15;
        default: w = 1000;
      endcase
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
          w, $urandom_range(0, 3));
    end

    // RDATA_LAT = 0: data captured on the ack edge
    for (int n = 0; n < 4; n++) begin
      logic [7:0] v;
      bit         w0;
      v  = 8'($urandom);
      w0 = (n % 2) == 1;
      r0_rdat      = v;
      r0_req_valid = 1'b1;
      r0_req_we    = w0;
      r0_req_adr   = 2'($urandom_range(0, 3));
      r0_req_dat   = 8'($urandom);
      @(negedge clk_i);
      r0_req_valid = 1'b0;
      chk("lat0_cyc", {31'd0, r0_cyc}, 32'd1);
      @(negedge clk_i);
      chk("lat0_rsp", {22'd0, r0_rsp_valid, r0_rsp_err, r0_rsp_dat, r0_cyc},
          {22'd0, 1'b1, 1'b0, (w0 ? 8'h00 : v), 1'b0});
      r0_rsp_ready = 1'b1;
      @(negedge clk_i);
      r0_rsp_ready = 1'b0;
      chk("lat0_idle", {31'd0, r0_req_ready}, 32'd1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_host.md
# wb_host

Single-outstanding 8-bit WISHBONE initiator. It turns a valid/ready request stream into one classic WISHBONE read or write cycle and returns the result on a valid/ready response stream. It drives the control and status slaves (GPIO, instruction-base and similar register blocks) from a sequencer or host-interface front end. A programmable ack timeout and an optional read-data delay support slaves whose `dat_o` is registered one cycle after the address.

## Interface
- `ADDR_W`, 2: width of `adr_o` and `req_adr_i`.
- `TIMEOUT`, 15: maximum bus cycles to wait for `ack_i` (≥1); counter width is clog2(TIMEOUT+1).
- `RDATA_LAT`, 1: read-data delay after ack, 0 or 1 cycles; applies to reads only.
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  request accepted when high with `req_valid_i`.
- `req_we_i`  in  1  1 = write, 0 = read.
- `req_adr_i`  in  ADDR_W  target address.
- `req_dat_i`  in  8  write data.
- `rsp_valid_o`  out  1  response present.
- `rsp_ready_i`  in  1  response consumed when high with `rsp_valid_o`.
- `rsp_dat_o`  out  8  read data (0 for writes and on error).
- `rsp_err_o`  out  1  1 = timeout, no ack received.
- `cyc_o`, `stb_o`  out  1  WISHBONE cycle/strobe, always equal.
- `we_o`  out  1  WISHBONE write enable.
- `adr_o`  out  ADDR_W  WISHBONE address.
- `dat_o`  out  8  WISHBONE write data.
- `dat_i`  in  8  WISHBONE read data.
- `ack_i`  in  1  WISHBONE acknowledge; may be combinational from `cyc_o & stb_o`.

## Operation
- FSM states:
  - IDLE: `req_ready_o` = 1. On `req_valid_i`, latch `we_o`/`adr_o`/`dat_o` from the request, clear the timeout counter and go to BUS.
  - BUS: `cyc_o` = `stb_o` = 1. The counter increments each cycle without ack.
    - `ack_i` high on a write: err = 0, dat = 0, go to RESP.
    - `ack_i` high on a read with RDATA_LAT = 0: capture `dat_i` at that edge, go to RESP.
    - `ack_i` high on a read with RDATA_LAT = 1: go to RDLY.
    - Counter = TIMEOUT−1 with no ack: err = 1, dat = 0, go to RESP.
    - Ack on the final timeout cycle wins; err = 0.
  - RDLY: `cyc_o` = `stb_o` = 0, `adr_o` held. Capture `dat_i` at the end of the cycle, go to RESP.
  - RESP: `rsp_valid_o` = 1, `rsp_dat_o` and `rsp_err_o` stable. On `rsp_ready_i`, go to IDLE.
- `req_ready_o` and `rsp_valid_o` decode from state. `cyc_o`, `stb_o`, `we_o`, `adr_o` and `dat_o` are registers.
- `adr_o`, `we_o` and `dat_o` change only on request acceptance, so the address stays stable through RDLY and RESP.
- The block never issues a new cycle while a response is pending; one transaction is outstanding at a time.

## Timing
- Reset (`rst_i` low) forces state IDLE immediately and clears all registers to 0: `cyc_o`, `stb_o`, `we_o`, `adr_o`, `dat_o`, `rsp_dat_o`, `rsp_err_o`, `rsp_valid_o`, counter.
- `req_ready_o` reads 1 as soon as reset is released.
- Reset mid-cycle drops `cyc_o`/`stb_o` asynchronously. The pending transaction and response are discarded.
- Request accepted at edge k:
  - `cyc_o` is high during cycle k+1.
  - Zero-wait ack in cycle k+1 gives `rsp_valid_o` in cycle k+2 for writes and for reads with RDATA_LAT = 0.
  - For reads with RDATA_LAT = 1, `rsp_valid_o` rises in cycle k+3.
- `cyc_o` falls on the edge where ack is sampled; strobe is exactly one cycle for zero-wait slaves.
- A slave holding ack for multiple cycles is ignored after the first.
- Timeout: with no ack, `cyc_o` stays high for exactly TIMEOUT cycles, then `rsp_valid_o` rises with `rsp_err_o` = 1.
- Minimum transaction period is 3 cycles (IDLE, BUS, RESP), or 4 with RDLY, given `rsp_ready_i` held high.
- Response backpressure: `rsp_valid_o` and data stay held indefinitely until `rsp_ready_i`. `req_ready_o` stays 0 meanwhile.

## Test plan
- Write with zero-wait combinational-ack slave:
  - Stimulus: req we = 1, adr = 1, dat = 0xA5, accepted at edge k.
  - Response: `cyc_o`/`stb_o`/`we_o` high only in cycle k+1 with adr_o = 1, dat_o = 0xA5; `rsp_valid_o` in k+2 with err = 0, dat = 0.
- Read, registered-data slave, RDATA_LAT = 1:
  - Stimulus: slave ack is combinational; slave returns 0x3C registered one cycle after adr = 2.
  - Response: `rsp_dat_o` = 0x3C in cycle k+3. With RDATA_LAT = 0 the same slave returns its stale prior value, which is expected.
- Timeout, TIMEOUT = 15, ack tied 0:
  - Response: `cyc_o` high exactly 15 cycles, then `rsp_valid_o` = 1, `rsp_err_o` = 1, `rsp_dat_o` = 0.
  - Repeat with ack asserted on cycle 15: err = 0.
- Wait-state slave acking after 3 cycles, read returning 0x81:
  - Response: `cyc_o` high 3 cycles, response dat = 0x81, err = 0.
  - A second ack held high afterwards causes no extra transaction.
- Backpressure and back-to-back:
  - Stimulus: `rsp_ready_i` low for 10 cycles with `req_valid_i` held high.
  - Response: response held stable, `req_ready_o` = 0, no `cyc_o`. After ready, the next request is accepted in IDLE, giving a 3-cycle period.
- Async reset during BUS (mid-wait):
  - Response: `cyc_o`/`stb_o` drop in the same cycle without a clock edge, all outputs 0, no response emitted.
  - After release, a fresh write completes normally.
